mem_port_arbiter: RTL

Two-requester arbiter that shares the CPU's single external memory port between the instruction-fetch side (port 0) and the data-access side (port 1). It owns the select line of the shared 2:1 address/command multiplexer and sequences one transaction at a time through address and data phases. Round-robin selection prevents starvation. The block sits between the pipeline's fetch/memory stages and the SRAM-style bridge.

---
 rtl/mem_port_arbiter_if.sv | 42 ++++
 rtl/mem_port_arbiter.sv | 84 ++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Shared memory-port bundle: two requester ports on one side, the SRAM-style
// bridge on the other. The arbiter sits on the slave modport.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req,     m1_req;
  logic          m0_wr,      m1_wr;
  logic [1:0]    m0_size,    m1_size;
  logic [AW-1:0] m0_addr,    m1_addr;
  logic [DW-1:0] m0_wdata,   m1_wdata;
  logic          m0_addr_ok, m1_addr_ok;
  logic          m0_data_ok, m1_data_ok;
  logic [DW-1:0] m_rdata;

  logic          s_req;
  logic          s_wr;
  logic [1:0]    s_size;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_addr_ok;
  logic          s_data_ok;
  logic [DW-1:0] s_rdata;

  // Arbiter view.
  modport slave (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_size, m1_size,
           m0_addr, m1_addr, m0_wdata, m1_wdata,
           s_addr_ok, s_data_ok, s_rdata,
    output m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, m_rdata,
           s_req, s_wr, s_size, s_addr, s_wdata
  );

  // Requester/bridge view.
  modport master (
    output m0_req, m1_req, m0_wr, m1_wr, m0_size, m1_size,
           m0_addr, m1_addr, m0_wdata, m1_wdata,
           s_addr_ok, s_data_ok, s_rdata,
    input  m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok, m_rdata,
           s_req, s_wr, s_size, s_addr, s_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between instruction
// fetch (port 0) and data access (port 1); one transaction in flight at a time.
module mem_port_arbiter (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state;
  logic   grant;   // port owning the current (or most recent) transaction
  logic   last;    // port that most recently completed
  logic   s_req_q;

  logic   addr_ok;
  logic   data_ok;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      grant   <= 1'b0;
      last    <= 1'b1;
      s_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.m0_req || bus.m1_req) begin
            // On a tie the port not served last wins; otherwise the lone requester.
            grant   <= (bus.m0_req && bus.m1_req) ? ~last : bus.m1_req;
            s_req_q <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (bus.s_addr_ok) begin
            s_req_q <= 1'b0;
            if (bus.s_data_ok) begin
              last  <= grant;
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.s_data_ok) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: begin
          s_req_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Handshakes pass straight through so a same-cycle bridge response is not delayed.
  assign addr_ok = (state == REQ) && bus.s_addr_ok;
  assign data_ok = ((state == REQ) && bus.s_addr_ok && bus.s_data_ok) ||
                   ((state == WAIT) && bus.s_data_ok);

  assign bus.m0_addr_ok = addr_ok && !grant;
  assign bus.m1_addr_ok = addr_ok &&  grant;
  assign bus.m0_data_ok = data_ok && !grant;
  assign bus.m1_data_ok = data_ok &&  grant;
  assign bus.m_rdata    = bus.s_rdata;

  // Field mux follows grant in every state; s_req alone qualifies it.
  assign bus.s_req   = s_req_q;
  assign bus.s_wr    = grant ? bus.m1_wr    : bus.m0_wr;
  assign bus.s_size  = grant ? bus.m1_size  : bus.m0_size;
  assign bus.s_addr  = grant ? bus.m1_addr  : bus.m0_addr;
  assign bus.s_wdata = grant ? bus.m1_wdata : bus.m0_wdata;

endmodule
